// File: rtl/p2p_perf_mon.sv
// p2p_perf_mon: PCIM peer-to-peer latency/throughput monitor on the CL config bus.
// Runs N trials of read RTT (mode 0), write RTT (mode 1) or throughput (mode 2).
// Each trial stores one cycle-count sample. Trials are bounded by an optional timeout
// and can be aborted.
// Optional feature: define P2P_PERF_STATS_EN to build the running sum/min/max
// accumulators. Without it, offsets 0x14-0x28 read 32'h0BAD_F00D.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_wr/cfg_rd/cfg_addr/...  config access; cfg_ack/cfg_rd_data 2 cycles later
//   pcim_r*/pcim_b*/tp_tx_done  completion event sources
//   pcim_cntrl                  one-cycle issue pulse, [0] read, [1] write
//   busy, done_irq              test in progress, normal-completion pulse
module p2p_perf_mon #(
  parameter int          CNTR_WIDTH  = 64,
  parameter int          NUM_SAMPLES = 64,
  parameter logic [31:0] BASE_ADDR   = 32'hE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [31:0] cfg_rd_data,
  input  logic        pcim_rvalid,
  input  logic        pcim_rready,
  input  logic        pcim_rlast,
  input  logic        pcim_bvalid,
  input  logic        pcim_bready,
  input  logic        tp_tx_done,
  output logic [1:0]  pcim_cntrl,
  output logic        busy,
  output logic        done_irq
);
  localparam int                    IW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [31:0]           BAD  = 32'h0BAD_F00D;
  localparam logic [CNTR_WIDTH-1:0] ONES = '1;
  localparam logic [8:0]            NS9  = 9'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PAUSE} state_t;
  state_t state, state_nxt;

  logic [7:0]  num_trials, tp_num_trans, trials_done, tp_cnt;
  logic [31:0] pause_cyc, timeout_cyc, pcnt;
  logic [1:0]  mode;
  logic [8:0]  trials_tgt;
  logic        done, timeout_err, ack1;
  logic [31:0] rdq1;
  logic [CNTR_WIDTH-1:0] cnt, cnt_inc;
  logic [CNTR_WIDTH-1:0] samples [NUM_SAMPLES];
`ifdef P2P_PERF_STATS_EN
  logic [CNTR_WIDTH-1:0] sum, mn, mx;
  logic [CNTR_WIDTH:0]   sum_add;
  assign sum_add = {1'b0, sum} + {1'b0, cnt_inc};
`endif

  // Address decode: the window is 4 KB so the full 256-entry sample region fits.
  logic [31:0] off;
  logic        in_win, wr_hit, wr_ctrl, start_ok, abort;
  assign off      = cfg_addr - BASE_ADDR;
  assign in_win   = (cfg_addr >= BASE_ADDR) && (off < 32'h1000);
  assign wr_hit   = cfg_wr && in_win;
  assign wr_ctrl  = wr_hit && (off == 32'h0);
  assign start_ok = wr_ctrl && cfg_wdata[0] && !cfg_wdata[1] && (state == IDLE) &&
                    (num_trials != 8'd0) && (cfg_wdata[3:2] != 2'd3);
  assign abort    = wr_ctrl && cfg_wdata[1] && (state != IDLE);

  // Completion and timeout detection
  logic       ev, complete, tmo, last;
  logic [7:0] tp_tgt;
  logic [31:0] pause_eff;
  assign tp_tgt    = (tp_num_trans == 8'd0) ? 8'd1 : tp_num_trans;
  assign pause_eff = (pause_cyc == 32'd0) ? 32'd1 : pause_cyc;
  assign cnt_inc   = (cnt == ONES) ? cnt : cnt + 1'b1;
  always_comb begin
    case (mode)
      2'd0:    ev = pcim_rvalid & pcim_rready & pcim_rlast;
      2'd1:    ev = pcim_bvalid & pcim_bready;
      default: ev = tp_tx_done;
    endcase
  end
  assign complete = (state == WAIT) && ev &&
                    ((mode != 2'd2) || ({1'b0, tp_cnt} + 9'd1 == {1'b0, tp_tgt}));
  assign tmo  = (state == WAIT) && !complete && (timeout_cyc != 32'd0) &&
                (64'(cnt_inc) == 64'(timeout_cyc));
  assign last = ({1'b0, trials_done} + 9'd1 == trials_tgt);

  always_comb begin
    state_nxt  = state;
    pcim_cntrl = 2'b00;
    case (state)
      IDLE:  if (start_ok) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt  = WAIT;
        pcim_cntrl = (mode == 2'd0) ? 2'b01 : 2'b10;
      end
      WAIT:  if (complete) state_nxt = last ? IDLE : PAUSE;
             else if (tmo) state_nxt = IDLE;
      PAUSE: if (pcnt >= pause_eff) state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {num_trials, tp_num_trans, pause_cyc, timeout_cyc} <= '0;
      {mode, trials_tgt, trials_done, tp_cnt, pcnt, cnt} <= '0;
      {done, timeout_err, busy, done_irq} <= '0;
`ifdef P2P_PERF_STATS_EN
      sum <= '0; mx <= '0; mn <= ONES;
`endif
    end else begin
      state    <= state_nxt;
      done_irq <= 1'b0;
      if (wr_hit) begin
        case (off[11:0])
          12'h004: {tp_num_trans, num_trials} <= cfg_wdata[15:0];
          12'h008: pause_cyc   <= cfg_wdata;
          12'h00C: timeout_cyc <= cfg_wdata;
          default: ;
        endcase
      end
      if (start_ok) begin
        mode        <= cfg_wdata[3:2];
        trials_tgt  <= ({1'b0, num_trials} > NS9) ? NS9 : {1'b0, num_trials};
        trials_done <= '0;
        {done, timeout_err} <= '0;
        busy        <= 1'b1;
`ifdef P2P_PERF_STATS_EN
        sum <= '0; mx <= '0; mn <= ONES;
`endif
      end
      if (abort) begin
        busy <= 1'b0;
      end else begin
        case (state)
          ISSUE: begin cnt <= '0; tp_cnt <= '0; end
          WAIT: begin
            cnt <= cnt_inc;
            if (ev) tp_cnt <= tp_cnt + 8'd1;
            if (complete) begin
              trials_done <= trials_done + 8'd1;
              pcnt        <= 32'd1;
`ifdef P2P_PERF_STATS_EN
              sum <= sum_add[CNTR_WIDTH] ? ONES : sum_add[CNTR_WIDTH-1:0];
              if (cnt_inc < mn) mn <= cnt_inc;
              if (cnt_inc > mx) mx <= cnt_inc;
`endif
              if (last) begin busy <= 1'b0; done <= 1'b1; done_irq <= 1'b1; end
            end else if (tmo) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
            end
          end
          PAUSE: pcnt <= pcnt + 32'd1;
          default: ;
        endcase
      end
    end
  end

  // Sample store is RAM-like; stale contents stay hidden behind the valid count.
  always_ff @(posedge clk)
    if (!rst && !abort && (complete || tmo))
      samples[trials_done[IW-1:0]] <= complete ? cnt_inc : ONES;

  // A timed-out trial is not counted in trials_done, but its all-ones sample
  // is still readable so software can see which trial expired.
  logic [8:0]  samp_vld, sidx;
  logic [11:0] soff;
  logic [63:0] sx;
  logic [31:0] rdata;
  assign samp_vld = {1'b0, trials_done} + {8'h0, timeout_err};
  assign soff     = off[11:0] - 12'h100;
  assign sidx     = soff[11:3];

  always_comb begin
    rdata = BAD;
    sx    = '0;
    case (off[11:0])
      12'h000: rdata = '0;
      12'h004: rdata = {16'h0, tp_num_trans, num_trials};
      12'h008: rdata = pause_cyc;
      12'h00C: rdata = timeout_cyc;
      12'h010: rdata = {16'h0, trials_done, 5'h0, timeout_err, done, busy};
`ifdef P2P_PERF_STATS_EN
      12'h014: rdata = 32'(64'(sum));
      12'h018: rdata = 32'(64'(sum) >> 32);
      12'h01C: rdata = 32'(64'(mn));
      12'h020: rdata = 32'(64'(mn) >> 32);
      12'h024: rdata = 32'(64'(mx));
      12'h028: rdata = 32'(64'(mx) >> 32);
`endif
      default: begin
        if (off[11:0] >= 12'h100 && off[11:0] < 12'h900 && off[1:0] == 2'b00) begin
          rdata = '0;
          if (sidx < samp_vld) begin
            sx    = 64'(samples[sidx[IW-1:0]]);
            rdata = off[2] ? sx[63:32] : sx[31:0];
          end
        end
      end
    endcase
  end

  // Two-stage ack pipeline: read data snapshots at the access edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      {ack1, cfg_ack} <= '0;
      rdq1 <= '0; cfg_rd_data <= '0;
    end else begin
      ack1        <= in_win && (cfg_rd || cfg_wr);
      rdq1        <= (in_win && cfg_rd) ? rdata : 32'h0;
      cfg_ack     <= ack1;
      cfg_rd_data <= rdq1;
    end
  end
endmodule
